com_mul: RTL and testbench

Complex multiplier with an internal twiddle-factor ROM for the 32-point IFFT datapath. It multiplies one complex sample by the IFFT twiddle W^k = exp(+j·2πk/32) selected by `twsel`. It sits between butterfly stages, and the product is registered once. It uses 36-bit signed fixed-point data where 1.0 = 2^28.

---
 rtl/com_mul.sv | 120 ++++++++++++
 tb/tb_com_mul.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/com_mul.sv
// ---------------------------------------------------------------------------
// com_mul
// Complex multiplier for the 32-point IFFT datapath. The input sample is
// multiplied by the IFFT twiddle W^k = exp(+j*2*pi*k/32), which is taken from
// an internal combinational ROM. The product is registered once.
//
// Number formats:
//   samples  : 36-bit signed, 1.0 = 2^28
//   twiddles : 18-bit signed, 1.0 = 2^16
//   products : full precision, then arithmetic shift right by 16 and wrap to
//              36 bits (no saturation, truncation toward -inf)
//
// Ports:
//   clk    in   1   system clock, rising-edge active
//   rst    in   1   asynchronous reset, active low (0 = reset)
//   dir    in  36   real part of input sample
//   dii    in  36   imaginary part of input sample
//   twsel  in   7   twiddle index, only bits [4:0] are used
//   dor    out 36   real part of product, registered
//   doi    out 36   imaginary part of product, registered
// ---------------------------------------------------------------------------
module com_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] dir,
    input  logic [35:0] dii,
    input  logic [6:0]  twsel,
    output logic [35:0] dor,
    output logic [35:0] doi
);

    // First octant of round(cos(2*pi*m/32) * 65536), m = 0..8. Every other
    // entry of both the cosine and sine tables is folded onto these values.
    function automatic logic signed [17:0] cos_octant(input logic [3:0] m);
        logic signed [17:0] v;
        case (m)
            4'd0:    v = 18'sd65536;
            4'd1:    v = 18'sd64277;
            4'd2:    v = 18'sd60547;
            4'd3:    v = 18'sd54491;
            4'd4:    v = 18'sd46341;
            4'd5:    v = 18'sd36410;
            4'd6:    v = 18'sd25080;
            4'd7:    v = 18'sd12785;
            default: v = 18'sd0;
        endcase
        return v;
    endfunction

    // Full-circle cosine from the first octant.
    // cos is even, so k and 32-k (i.e. -k mod 32) share a value; on the half
    // circle m = 0..16 the second quarter mirrors the first with a sign flip.
    // Symmetric rounding (ties away from zero) keeps the folded values exact.
    function automatic logic signed [17:0] cos_lookup(input logic [4:0] k);
        logic [4:0]         m;
        logic [4:0]         mirror;
        logic signed [17:0] v;
        m = (k > 5'd16) ? (5'd0 - k) : k;
        mirror = 5'd16 - m;
        if (m > 5'd8) begin
            v = -cos_octant(mirror[3:0]);
        end else begin
            v = cos_octant(m[3:0]);
        end
        return v;
    endfunction

    logic [4:0]         k;
    logic signed [17:0] wr;
    logic signed [17:0] wi;
    logic signed [35:0] sdr;
    logic signed [35:0] sdi;
    logic signed [53:0] p_rr;
    logic signed [53:0] p_ii;
    logic signed [53:0] p_ri;
    logic signed [53:0] p_ir;
    logic signed [54:0] pr;
    logic signed [54:0] pi;
    logic               unused_bits;

    assign k   = twsel[4:0];
    assign sdr = $signed(dir);
    assign sdi = $signed(dii);

    // Twiddle ROM: sin(x) = cos(x - pi/2), so the imaginary part is the
    // cosine table read a quarter turn (8 entries) earlier.
    always_comb begin
        wr = cos_lookup(k);
        wi = cos_lookup(k - 5'd8);
    end

    // Full-precision multiply-add. The sums carry one guard bit over the
    // 54-bit products so the 1+j by 1.0 corner cannot overflow before the
    // shift.
    always_comb begin
        p_rr = sdr * wr;
        p_ii = sdi * wi;
        p_ri = sdr * wi;
        p_ir = sdi * wr;
        pr   = $signed({p_rr[53], p_rr}) - $signed({p_ii[53], p_ii});
        pi   = $signed({p_ri[53], p_ri}) + $signed({p_ir[53], p_ir});
    end

    // Scaling keeps bits [51:16]: an arithmetic shift by 16 followed by a
    // wrap to 36 bits. The discarded bits are gathered here on purpose.
    assign unused_bits = ^{twsel[6:5], pr[54:52], pr[15:0], pi[54:52], pi[15:0]};

    // Output register: the only state in the block. Reset clears it
    // asynchronously so the outputs drop to zero even mid-stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dor <= 36'd0;
            doi <= 36'd0;
        end else begin
            dor <= pr[51:16];
            doi <= pi[51:16];
        end
    end

endmodule

// File: tb/tb_com_mul.sv
// ---------------------------------------------------------------------------
// tb_com_mul
// Self-checking bench for com_mul: reset behaviour, a table of directed
// vectors with hand-computed results, a full twiddle sweep, mid-stream reset
// and a back-to-back random run against an independent reference model.
// ---------------------------------------------------------------------------
module tb_com_mul;

    logic        clk;
    logic        rst;
    logic [35:0] dir;
    logic [35:0] dii;
    logic [6:0]  twsel;
    logic [35:0] dor;
    logic [35:0] doi;

    int total;
    int bad;

    com_mul dut (
        .clk   (clk),
        .rst   (rst),
        .dir   (dir),
        .dii   (dii),
        .twsel (twsel),
        .dor   (dor),
        .doi   (doi)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference twiddle tables written out in full, independent of the
    // folding used in the design.
    int romc [32] = '{
        65536,  64277,  60547,  54491,  46341,  36410,  25080,  12785,
        0,     -12785, -25080, -36410, -46341, -54491, -60547, -64277,
        -65536, -64277, -60547, -54491, -46341, -36410, -25080, -12785,
        0,      12785,  25080,  36410,  46341,  54491,  60547,  64277
    };
    int roms [32] = '{
        0,      12785,  25080,  36410,  46341,  54491,  60547,  64277,
        65536,  64277,  60547,  54491,  46341,  36410,  25080,  12785,
        0,     -12785, -25080, -36410, -46341, -54491, -60547, -64277,
        -65536, -64277, -60547, -54491, -46341, -36410, -25080, -12785
    };

    // Bit-exact model: 64-bit signed arithmetic, shift by 16, keep 36 bits.
    function automatic logic [71:0] model(input logic [35:0] a, input logic [35:0] b,
                                          input logic [6:0] t);
        longint sa;
        longint sb;
        longint cr;
        longint ci;
        longint xr;
        longint xi;
        logic [63:0] ur;
        logic [63:0] ui;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cr = longint'(romc[t[4:0]]);
        ci = longint'(roms[t[4:0]]);
        xr = (sa * cr - sb * ci) >>> 16;
        xi = (sa * ci + sb * cr) >>> 16;
        ur = xr;
        ui = xi;
        return {ur[35:0], ui[35:0]};
    endfunction

    typedef struct {
        logic [35:0] vdr;
        logic [35:0] vdi;
        logic [6:0]  vtw;
        logic [35:0] er;
        logic [35:0] ei;
    } vec_t;

    vec_t vecs [13];

    // Drive one input set away from the active edge.
    task automatic applyStimulus(input logic [35:0] a, input logic [35:0] b,
                                 input logic [6:0] t);
        @(negedge clk);
        dir   = a;
        dii   = b;
        twsel = t;
    endtask

    // Compare both outputs as one check.
    task automatic checkOutput(input string name, input logic [35:0] er,
                               input logic [35:0] ei);
        total++;
        if (dor !== er || doi !== ei) begin
            bad++;
            $display("[TB] FAIL %s: got dor=%h doi=%h, expected dor=%h doi=%h",
                     name, dor, doi, er, ei);
        end
    endtask

    logic [71:0] expv;
    logic [63:0] r64a;
    logic [63:0] r64b;

    initial begin
        total = 0;
        bad   = 0;

        // Directed vectors with hand-computed results.
        vecs[0]  = '{36'h010000000, 36'h0,          7'd0,   36'h010000000, 36'h000000000};
        vecs[1]  = '{36'h010000000, 36'h0,          7'd4,   36'h00B505000, 36'h00B505000};
        vecs[2]  = '{36'h010000000, 36'h0,          7'd8,   36'h000000000, 36'h010000000};
        vecs[3]  = '{36'h010000000, 36'h0,          7'd16,  36'hFF0000000, 36'h000000000};
        vecs[4]  = '{36'h010000000, 36'h0,          7'd24,  36'h000000000, 36'hFF0000000};
        vecs[5]  = '{36'h010000000, 36'h010000000,  7'd8,   36'hFF0000000, 36'h010000000};
        vecs[6]  = '{36'h010000000, 36'h0,          7'd40,  36'h000000000, 36'h010000000};
        vecs[7]  = '{36'hFFFFFFFFF, 36'h0,          7'd4,   36'hFFFFFFFFF, 36'hFFFFFFFFF};
        vecs[8]  = '{36'h010000000, 36'h0,          7'd1,   36'h00FB15000, 36'h0031F1000};
        vecs[9]  = '{36'h010000000, 36'h0,          7'd127, 36'h00FB15000, 36'hFFCE0F000};
        vecs[10] = '{36'h7FFFFFFFF, 36'h0,          7'd0,   36'h7FFFFFFFF, 36'h000000000};
        vecs[11] = '{36'h800000000, 36'h0,          7'd16,  36'h800000000, 36'h000000000};
        vecs[12] = '{36'h000010000, 36'h0,          7'd1,   36'h00000FB15, 36'h0000031F1};

        // Reset held with arbitrary inputs and a running clock.
        rst   = 1'b0;
        dir   = 36'h123456789;
        dii   = 36'h9ABCDEF01;
        twsel = 7'd5;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", 36'h0, 36'h0);

        // Release: the first edge loads the product of the inputs present.
        @(negedge clk);
        rst = 1'b1;
        expv = model(dir, dii, twsel);
        @(posedge clk);
        #1;
        checkOutput("reset_release", expv[71:36], expv[35:0]);

        // Table-driven directed vectors.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].vdr, vecs[i].vdi, vecs[i].vtw);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].er, vecs[i].ei);
        end

        // Twiddle sweep, one index per cycle, 1.0 input.
        for (int t = 0; t < 32; t++) begin
            logic [35:0] swr;
            logic [35:0] swi;
            applyStimulus(36'h010000000, 36'h0, 7'(t));
            swr = 36'(romc[t] * 4096);
            swi = 36'(roms[t] * 4096);
            @(posedge clk);
            #1;
            checkOutput($sformatf("sweep%0d", t), swr, swi);
        end

        // Inputs changing between edges must not reach the outputs.
        applyStimulus(36'h010000000, 36'h0, 7'd2);
        @(posedge clk);
        #1;
        dir   = 36'h0ABCDEF12;
        twsel = 7'd13;
        #2;
        checkOutput("between_edges", 36'h00EC83000, 36'h0061F8000);

        // Mid-stream asynchronous reset.
        applyStimulus(36'h010000000, 36'h010000000, 7'd3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_async", 36'h0, 36'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_stays", 36'h0, 36'h0);
        @(negedge clk);
        rst   = 1'b1;
        dir   = 36'h010000000;
        dii   = 36'h010000000;
        twsel = 7'd8;
        @(posedge clk);
        #1;
        checkOutput("reset_reload", 36'hFF0000000, 36'h010000000);

        // Back-to-back random operations with one cycle of latency.
        for (int n = 0; n < 1200; n++) begin
            r64a = {$urandom(), $urandom()};
            r64b = {$urandom(), $urandom()};
            applyStimulus(r64a[35:0], r64b[35:0], 7'($urandom_range(127, 0)));
            expv = model(dir, dii, twsel);
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d", n), expv[71:36], expv[35:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
